// File: rtl/muldiv_pkg.sv
// muldiv_pkg: opcodes, control states and opcode decode helpers for muldiv_unit.
package muldiv_pkg;
  localparam int MD_OP_W = 4;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MSUBU = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd8;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd9;
  localparam logic [MD_OP_W-1:0] MD_MUL   = 4'd10;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} md_state_e;

  function automatic logic md_is_mul(input logic [MD_OP_W-1:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU, MD_MUL};
  endfunction

  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

  function automatic logic md_mul_signed(input logic [MD_OP_W-1:0] op);
    return op inside {MD_MULT, MD_MADD, MD_MSUB, MD_MUL};
  endfunction

  function automatic logic md_is_madd(input logic [MD_OP_W-1:0] op);
    return op inside {MD_MADD, MD_MADDU};
  endfunction

  function automatic logic md_is_msub(input logic [MD_OP_W-1:0] op);
    return op inside {MD_MSUB, MD_MSUBU};
  endfunction
endpackage

// File: rtl/div_iter.sv
// div_iter: radix-2 restoring divider on operand magnitudes, one quotient bit per cycle,
// with sign and divide-by-zero fix-up applied combinationally on the completion cycle.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start_i,
  input  logic            cancel_i,
  input  logic            sgn_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            complete_o,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);
  localparam int CW = $clog2(XLEN + 1);
  logic            active_q, qneg_q, rneg_q, dz_q, ge;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, a_q;
  logic [XLEN:0]   t, diff;

  always_comb begin
    t          = {rem_q, quo_q[XLEN-1]};
    diff       = t - {1'b0, dvs_q};
    ge         = t >= {1'b0, dvs_q};
    complete_o = active_q && cnt_q == CW'(XLEN);
    quo_o      = dz_q ? '1 : qneg_q ? -quo_q : quo_q;
    rem_o      = dz_q ? a_q : rneg_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= (sgn_i && a_i[XLEN-1]) ? -a_i : a_i;
      dvs_q    <= (sgn_i && b_i[XLEN-1]) ? -b_i : b_i;
      qneg_q   <= sgn_i && (a_i[XLEN-1] ^ b_i[XLEN-1]);
      rneg_q   <= sgn_i && a_i[XLEN-1];
      dz_q     <= b_i == '0;
      a_q      <= a_i;
    end else if (cancel_i || complete_o) begin
      active_q <= 1'b0;
    end else if (active_q) begin
      rem_q <= ge ? diff[XLEN-1:0] : t[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], ge};
      cnt_q <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO-owning multiply/divide unit with accumulate ops, GPR-result MUL,
// a MUL_STAGES-deep multiplier pipe, an iterative divider and flush support.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [MD_OP_W-1:0] req_op,
  input  logic [XLEN-1:0]    req_a,
  input  logic [XLEN-1:0]    req_b,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic               res_valid,
  output logic [XLEN-1:0]    res_data,
  output logic [XLEN-1:0]    hi,
  output logic [XLEN-1:0]    lo
);
  localparam int CW = $clog2(MUL_STAGES + 1);
  md_state_e          state_q;
  logic [CW-1:0]      cnt_q;
  logic [MD_OP_W-1:0] op_q;
  logic [XLEN-1:0]    a_q, b_q, hi_q, lo_q, res_data_q, div_quo, div_rem;
  logic               done_q, res_valid_q, accept, div_complete, msgn;
  logic [2*XLEN-1:0]  ext_a, ext_b, prod, mul_fin, hilo, acc;

  assign busy      = state_q != ST_IDLE;
  assign req_ready = !busy;
  assign accept    = req_valid && req_ready && !flush;
  assign done      = done_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  // Operands stay frozen in a_q/b_q while busy, so the pipe only has to delay the product.
  always_comb begin
    msgn  = md_mul_signed(op_q);
    ext_a = {{XLEN{msgn & a_q[XLEN-1]}}, a_q};
    ext_b = {{XLEN{msgn & b_q[XLEN-1]}}, b_q};
    prod  = ext_a * ext_b;
    hilo  = {hi_q, lo_q};
    acc   = md_is_madd(op_q) ? hilo + mul_fin : md_is_msub(op_q) ? hilo - mul_fin : mul_fin;
  end

  if (MUL_STAGES > 1) begin : g_pipe
    logic [2*XLEN-1:0] pipe_q [MUL_STAGES-1];
    always_ff @(posedge clk) begin
      pipe_q[0] <= prod;
      for (int i = 1; i < MUL_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign mul_fin = pipe_q[MUL_STAGES-2];
  end else begin : g_nopipe
    assign mul_fin = prod;
  end

  div_iter #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (accept && md_is_div(req_op)),
    .cancel_i   (flush),
    .sgn_i      (req_op == MD_DIV),
    .a_i        (req_a),
    .b_i        (req_b),
    .complete_o (div_complete),
    .quo_o      (div_quo),
    .rem_o      (div_rem)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      res_data_q  <= '0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      if (accept) begin
        op_q    <= req_op;
        a_q     <= req_a;
        b_q     <= req_b;
        cnt_q   <= CW'(MUL_STAGES - 1);
        state_q <= md_is_mul(req_op) ? ST_MUL : md_is_div(req_op) ? ST_DIV : ST_IDLE;
        if (req_op == MD_MTHI) hi_q <= req_a;
        if (req_op == MD_MTLO) lo_q <= req_a;
      end else if (flush) begin
        state_q <= ST_IDLE;
      end else if (state_q == ST_MUL) begin
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_q <= ST_IDLE;
          if (op_q == MD_MUL) begin
            res_data_q  <= mul_fin[XLEN-1:0];
            res_valid_q <= 1'b1;
          end else begin
            {hi_q, lo_q} <= acc;
            done_q       <= 1'b1;
          end
        end
      end else if (state_q == ST_DIV && div_complete) begin
        state_q <= ST_IDLE;
        hi_q    <= div_rem;
        lo_q    <= div_quo;
        done_q  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors; the driver queues expected HI/LO/MUL results and a
// negedge monitor pops and compares them whenever done or res_valid pulses.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0, resetn = 1'b0, req_valid = 1'b0, flush = 1'b0;
  logic [3:0]  req_op = 4'hF;
  logic [31:0] req_a = '0, req_b = '0;
  logic        req_ready, busy, done, res_valid;
  logic [31:0] res_data, hi, lo;

  typedef struct {
    bit          is_res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0, errors = 0;

  muldiv_unit #(.XLEN(32), .MUL_STAGES(3)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .res_valid (res_valid),
    .res_data  (res_data),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      chk("ready_eq_not_busy", {31'b0, req_ready}, {31'b0, !busy});
      if (done && res_valid) begin
        errors++;
        $display("FAIL done_with_res_valid: done=1 res_valid=1 required not both");
      end
      if (done || res_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: done=%b res_valid=%b hi=%h lo=%h required no pulse", done, res_valid, hi, lo);
        end else begin
          e = sb.pop_front();
          chk("result_kind", {31'b0, res_valid}, {31'b0, e.is_res});
          chk("result_hi", hi, e.hi);
          chk("result_lo", lo, e.lo);
          if (e.is_res) chk("res_data", res_data, e.data);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'hF; req_a = 32'hA5A5_5A5A; req_b = 32'h5A5A_A5A5;
  endtask

  task automatic wait_idle(input string name, input int lat);
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(name, 32'(n), 32'(lat));
  endtask

  task automatic op_done(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] ehi, input logic [31:0] elo);
    sb.push_back('{1'b0, ehi, elo, 32'h0});
    issue(op, a, b);
    wait_idle({name, "_latency"}, lat);
  endtask

  task automatic op_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic [31:0] edata);
    sb.push_back('{1'b1, ehi, elo, edata});
    issue(MD_MUL, a, b);
    wait_idle({name, "_latency"}, 3);
  endtask

  task automatic move(input string name, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] ehi, input logic [31:0] elo);
    issue(op, a, 32'h0);
    wait_idle({name, "_busy"}, 0);
    chk({name, "_hi"}, hi, ehi);
    chk({name, "_lo"}, lo, elo);
  endtask

  task automatic flush_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int k, input logic [31:0] ehi, input logic [31:0] elo);
    issue(op, a, b);
    repeat (k - 1) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk({name, "_busy"}, {31'b0, busy}, 32'h0);
    repeat (40) @(negedge clk);
    chk({name, "_hi"}, hi, ehi);
    chk({name, "_lo"}, lo, elo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_res_valid", {31'b0, res_valid}, 32'h0);
    chk("reset_res_data", res_data, 32'h0);
    chk("reset_ready", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1;
    resetn = 1'b1;

    op_done("mult",   MD_MULT,  32'hFFFF_FFFE, 32'h3,         3,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    op_done("multu",  MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3,  32'hFFFF_FFFE, 32'h0000_0001);
    op_done("div_n7_2", MD_DIV, 32'hFFFF_FFF9, 32'h2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    op_done("div_7_n2", MD_DIV, 32'h7,         32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD);
    op_done("div_min_m1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
    op_done("divu_by0", MD_DIVU, 32'h5,        32'h0,         33, 32'h5,         32'hFFFF_FFFF);
    op_done("div_by0",  MD_DIV,  32'hFFFF_FFF9, 32'h0,        33, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    op_done("divu_100_7", MD_DIVU, 32'd100,    32'd7,         33, 32'h2,         32'hE);

    move("mtlo10", MD_MTLO, 32'hA, 32'h2, 32'hA);
    move("mthi0",  MD_MTHI, 32'h0, 32'h0, 32'hA);
    op_done("madd", MD_MADD, 32'h4, 32'hFFFF_FFFF, 3, 32'h0, 32'h6);
    move("mtlo0",  MD_MTLO, 32'h0, 32'h0, 32'h0);
    op_done("msubu", MD_MSUBU, 32'h1, 32'h1, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    op_mul("mul_6x7",   32'd6,         32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd42);
    op_mul("mul_m3x5",  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    @(posedge clk); #1;
    req_valid = 1'b1; req_op = MD_MTHI; req_a = 32'h1234; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'hF; flush = 1'b0;
    @(negedge clk);
    chk("mthi_flushed_hi", hi, 32'hFFFF_FFFF);

    move("unknown_op", 4'hC, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    move("mthi_0",  MD_MTHI, 32'h0,         32'h0, 32'hFFFF_FFFF);
    op_done("maddu_carry", MD_MADDU, 32'h1, 32'h1, 3, 32'h1, 32'h0);
    op_done("msub_neg",    MD_MSUB,  32'h2, 32'hFFFF_FFFD, 3, 32'h1, 32'h6);

    flush_op("flush_div", MD_DIVU, 32'd100, 32'd7, 5, 32'h1, 32'h6);
    op_done("div_after_flush", MD_DIVU, 32'd9, 32'd4, 33, 32'h1, 32'h2);
    flush_op("flush_mult", MD_MULT, 32'd2, 32'd3, 2, 32'h1, 32'h2);
    op_done("mult_after_flush", MD_MULTU, 32'd2, 32'd3, 3, 32'h0, 32'h6);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
